// File: rtl/traffic_phase_ctrl.sv
// Multi-phase intersection controller: GREEN -> YELLOW -> ALL_RED sequencing with
// demand-based phase skipping, actuated green extension, flash override and freeze.
module traffic_phase_ctrl #(
  parameter int NUM_PHASES   = 2,
  parameter int CNT_W        = 8,
  parameter int GREEN_MIN    = 8,
  parameter int GREEN_MAX    = 16,
  parameter int YELLOW_TIME  = 2,
  parameter int ALL_RED_TIME = 1,
  parameter int FLASH_HALF   = 4,
  localparam int PH_W = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  flash_mode,
  input  logic [NUM_PHASES-1:0] demand,
  output logic [NUM_PHASES-1:0] red,
  output logic [NUM_PHASES-1:0] yellow,
  output logic [NUM_PHASES-1:0] green,
  output logic [PH_W-1:0]       phase_o,
  output logic [1:0]            state_o,
  output logic                  phase_start
);

  typedef enum logic [1:0] {
    ST_ALL_RED = 2'd0,
    ST_GREEN   = 2'd1,
    ST_YELLOW  = 2'd2,
    ST_FLASH   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] ALL_RED_LAST = CNT_W'(ALL_RED_TIME - 1);
  localparam logic [CNT_W-1:0] GREEN_MIN_LAST = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] GREEN_MAX_LAST = CNT_W'(GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_TIME - 1);
  localparam logic [CNT_W-1:0] FLASH_LAST = CNT_W'(FLASH_HALF - 1);

  state_t                  state_reg, state_next;
  logic [CNT_W-1:0]        counter_reg, counter_next;
  logic [PH_W-1:0]         phase_reg, phase_next;
  logic [NUM_PHASES-1:0]   pending_reg, pending_next;
  logic                    blink_reg, blink_next;

  logic [NUM_PHASES-1:0]   served_mask;
  logic [NUM_PHASES-1:0]   yellow_sel;
  logic [PH_W-1:0]         cand_idx [NUM_PHASES];
  logic [NUM_PHASES-1:0]   cand_hit;
  logic [PH_W-1:0]         next_phase;
  logic                    green_done;

  // Candidate gi is phase+gi+1 modulo N; the last candidate is the current phase itself.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_PHASES; gi++) begin : g_cand
      logic [PH_W:0] sum;
      logic [PH_W:0] wrapped;
      assign sum = {1'b0, phase_reg} + (PH_W+1)'(gi + 1);
      assign wrapped = sum - (PH_W+1)'(NUM_PHASES);
      assign cand_idx[gi] = (sum >= (PH_W+1)'(NUM_PHASES)) ? wrapped[PH_W-1:0] : sum[PH_W-1:0];
      assign cand_hit[gi] = pending_reg[cand_idx[gi]];
    end
  endgenerate

  always_comb begin
    next_phase = cand_idx[0];
    for (int k = NUM_PHASES - 1; k >= 0; k--) begin
      if (cand_hit[k]) next_phase = cand_idx[k];
    end
  end

  assign green_done = ((counter_reg >= GREEN_MIN_LAST) && !demand[phase_reg]) ||
                      (counter_reg == GREEN_MAX_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= ST_ALL_RED;
      counter_reg <= '0;
      phase_reg   <= PH_W'(NUM_PHASES - 1);
      pending_reg <= '0;
      blink_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      counter_reg <= counter_next;
      phase_reg   <= phase_next;
      pending_reg <= pending_next;
      blink_reg   <= blink_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    counter_next = counter_reg;
    phase_next   = phase_reg;
    pending_next = pending_reg;
    blink_next   = blink_reg;
    if (flash_mode) begin
      pending_next = pending_reg | (demand & ~served_mask);
      if (state_reg != ST_FLASH) begin
        state_next   = ST_FLASH;
        counter_next = '0;
        blink_next   = 1'b1;
      end else if (counter_reg == FLASH_LAST) begin
        counter_next = '0;
        blink_next   = ~blink_reg;
      end else begin
        counter_next = counter_reg + 1'b1;
      end
    end else if (enable) begin
      pending_next = pending_reg | (demand & ~served_mask);
      counter_next = counter_reg + 1'b1;
      unique case (state_reg)
        ST_ALL_RED: begin
          if (counter_reg == ALL_RED_LAST) begin
            state_next   = ST_GREEN;
            phase_next   = next_phase;
            counter_next = '0;
            // Entering green serves the phase, overriding a same-cycle request.
            pending_next[next_phase] = 1'b0;
          end
        end
        ST_GREEN: begin
          if (green_done) begin
            state_next   = ST_YELLOW;
            counter_next = '0;
          end
        end
        ST_YELLOW: begin
          if (counter_reg == YELLOW_LAST) begin
            state_next   = ST_ALL_RED;
            counter_next = '0;
          end
        end
        ST_FLASH: begin
          state_next   = ST_ALL_RED;
          counter_next = '0;
        end
      endcase
    end
  end

  generate
    for (gi = 0; gi < NUM_PHASES; gi++) begin : g_lamp
      assign served_mask[gi] = (state_reg == ST_GREEN) && (phase_reg == PH_W'(gi));
      assign yellow_sel[gi]  = (state_reg == ST_YELLOW) && (phase_reg == PH_W'(gi));
      assign green[gi]  = served_mask[gi];
      assign yellow[gi] = yellow_sel[gi] || ((state_reg == ST_FLASH) && blink_reg);
      assign red[gi]    = (state_reg != ST_FLASH) && !served_mask[gi] && !yellow_sel[gi];
    end
  endgenerate

  assign phase_o     = phase_reg;
  assign state_o     = state_reg;
  assign phase_start = (state_reg == ST_GREEN) && (counter_reg == '0);

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed testbench for traffic_phase_ctrl; three instances cover N=2, N=3 and N=4.
module tb_traffic_phase_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b1;
  logic flash_mode = 1'b0;

  logic [1:0] demand2 = '0, red2, yellow2, green2;
  logic [0:0] phase_o2;
  logic [1:0] state_o2;
  logic       phase_start2;

  logic [2:0] demand3 = '0, red3, yellow3, green3;
  logic [1:0] phase_o3;
  logic [1:0] state_o3;
  logic       phase_start3;

  logic [3:0] demand4 = '0, red4, yellow4, green4;
  logic [1:0] phase_o4;
  logic [1:0] state_o4;
  logic       phase_start4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  traffic_phase_ctrl #(.NUM_PHASES(2)) u2 (
    .clk(clk), .reset(reset), .enable(enable), .flash_mode(flash_mode), .demand(demand2),
    .red(red2), .yellow(yellow2), .green(green2), .phase_o(phase_o2), .state_o(state_o2),
    .phase_start(phase_start2)
  );

  traffic_phase_ctrl #(.NUM_PHASES(3)) u3 (
    .clk(clk), .reset(reset), .enable(enable), .flash_mode(flash_mode), .demand(demand3),
    .red(red3), .yellow(yellow3), .green(green3), .phase_o(phase_o3), .state_o(state_o3),
    .phase_start(phase_start3)
  );

  traffic_phase_ctrl #(.NUM_PHASES(4)) u4 (
    .clk(clk), .reset(reset), .enable(enable), .flash_mode(flash_mode), .demand(demand4),
    .red(red4), .yellow(yellow4), .green(green4), .phase_o(phase_o4), .state_o(state_o4),
    .phase_start(phase_start4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    checks++;
    if ({red2, yellow2, green2, phase_o2, state_o2, phase_start2} !== {2'b11, 2'b00, 2'b00, 1'b1, 2'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_n2: got r=%b y=%b g=%b ph=%0d st=%0d ps=%b, want r=11 y=00 g=00 ph=1 st=0 ps=0",
               red2, yellow2, green2, phase_o2, state_o2, phase_start2);
    end
    checks++;
    if ({red3, phase_o3, state_o3} !== {3'b111, 2'd2, 2'd0}) begin
      errors++;
      $display("FAIL reset_n3: got r=%b ph=%0d st=%0d, want r=111 ph=2 st=0", red3, phase_o3, state_o3);
    end
    checks++;
    if ({red4, phase_o4, state_o4} !== {4'b1111, 2'd3, 2'd0}) begin
      errors++;
      $display("FAIL reset_n4: got r=%b ph=%0d st=%0d, want r=1111 ph=3 st=0", red4, phase_o4, state_o4);
    end
    $display("test_reset: done");
  endtask

  task automatic test_fixed_time();
    logic [1:0] exp_st;
    logic [0:0] exp_ph;
    logic [1:0] exp_g, exp_y, exp_r;
    logic       exp_ps;
    reset = 1'b0;
    demand2 = '0;
    for (int s = 1; s <= 23; s++) begin
      tick();
      if (s <= 8)       begin exp_st = 2'd1; exp_ph = 1'b0; end
      else if (s <= 10) begin exp_st = 2'd2; exp_ph = 1'b0; end
      else if (s == 11) begin exp_st = 2'd0; exp_ph = 1'b0; end
      else if (s <= 19) begin exp_st = 2'd1; exp_ph = 1'b1; end
      else if (s <= 21) begin exp_st = 2'd2; exp_ph = 1'b1; end
      else if (s == 22) begin exp_st = 2'd0; exp_ph = 1'b1; end
      else              begin exp_st = 2'd1; exp_ph = 1'b0; end
      exp_ps = (s == 1) || (s == 12) || (s == 23);
      exp_g = (exp_st == 2'd1) ? (2'b01 << exp_ph) : 2'b00;
      exp_y = (exp_st == 2'd2) ? (2'b01 << exp_ph) : 2'b00;
      exp_r = ~(exp_g | exp_y);
      checks++;
      if ({state_o2, phase_o2, red2, yellow2, green2, phase_start2} !== {exp_st, exp_ph, exp_r, exp_y, exp_g, exp_ps}) begin
        errors++;
        $display("FAIL fixed_cycle_%0d: got st=%0d ph=%0d r=%b y=%b g=%b ps=%b, want st=%0d ph=%0d r=%b y=%b g=%b ps=%b",
                 s, state_o2, phase_o2, red2, yellow2, green2, phase_start2,
                 exp_st, exp_ph, exp_r, exp_y, exp_g, exp_ps);
      end
      checks++;
      if (((red2 | yellow2 | green2) !== 2'b11) || (((red2 & yellow2) | (red2 & green2) | (yellow2 & green2)) !== 2'b00)) begin
        errors++;
        $display("FAIL one_lamp_%0d: got r=%b y=%b g=%b, want exactly one lamp per phase", s, red2, yellow2, green2);
      end
    end
    $display("test_fixed_time: 23 cycles sampled");
  endtask

  task automatic test_actuation();
    int cnt;
    int guard;
    // demand held: green capped at the maximum
    apply_reset();
    demand2 = 2'b01;
    tick();
    cnt = 1;
    guard = 0;
    while (state_o2 == 2'd1 && guard < 40) begin
      tick();
      guard++;
      if (state_o2 == 2'd1) cnt++;
    end
    demand2 = '0;
    checks++;
    if (cnt !== 16 || state_o2 !== 2'd2) begin
      errors++;
      $display("FAIL green_capped: got length=%0d st=%0d, want length=16 st=2", cnt, state_o2);
    end
    // demand dropped in green cycle 11
    apply_reset();
    demand2 = 2'b01;
    tick();
    cnt = 1;
    guard = 0;
    while (state_o2 == 2'd1 && guard < 40) begin
      if (cnt == 11) demand2 = '0;
      tick();
      guard++;
      if (state_o2 == 2'd1) cnt++;
    end
    demand2 = '0;
    checks++;
    if (cnt !== 11 || state_o2 !== 2'd2) begin
      errors++;
      $display("FAIL green_extended: got length=%0d st=%0d, want length=11 st=2", cnt, state_o2);
    end
    // no demand: minimum green
    apply_reset();
    tick();
    cnt = 1;
    guard = 0;
    while (state_o2 == 2'd1 && guard < 40) begin
      tick();
      guard++;
      if (state_o2 == 2'd1) cnt++;
    end
    checks++;
    if (cnt !== 8) begin
      errors++;
      $display("FAIL green_minimum: got length=%0d, want length=8", cnt);
    end
    $display("test_actuation: done");
  endtask

  task automatic test_skip();
    int guard;
    apply_reset();
    tick();
    checks++;
    if ({state_o4, phase_o4} !== {2'd1, 2'd0}) begin
      errors++;
      $display("FAIL skip_start: got st=%0d ph=%0d, want st=1 ph=0", state_o4, phase_o4);
    end
    demand4 = 4'b0100;
    tick();
    demand4 = '0;
    guard = 0;
    while (state_o4 == 2'd1 && guard < 50) begin tick(); guard++; end
    while (state_o4 != 2'd1 && guard < 50) begin tick(); guard++; end
    checks++;
    if ({phase_o4, phase_start4} !== {2'd2, 1'b1} || guard !== 10) begin
      errors++;
      $display("FAIL skip_to_2: got ph=%0d ps=%b after %0d cycles, want ph=2 ps=1 after 10 cycles",
               phase_o4, phase_start4, guard);
    end
    guard = 0;
    while (state_o4 == 2'd1 && guard < 50) begin tick(); guard++; end
    while (state_o4 != 2'd1 && guard < 50) begin tick(); guard++; end
    checks++;
    if ({phase_o4, guard < 50} !== {2'd3, 1'b1}) begin
      errors++;
      $display("FAIL skip_pending_cleared: got ph=%0d, want ph=3 (fallback)", phase_o4);
    end
    $display("test_skip: done");
  endtask

  task automatic test_flash();
    logic [1:0] exp_y;
    apply_reset();
    tick();
    tick();
    tick();
    flash_mode = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      exp_y = (((i / 4) % 2) == 0) ? 2'b11 : 2'b00;
      checks++;
      if ({state_o2, red2, green2, yellow2} !== {2'd3, 2'b00, 2'b00, exp_y}) begin
        errors++;
        $display("FAIL flash_%0d: got st=%0d r=%b g=%b y=%b, want st=3 r=00 g=00 y=%b",
                 i, state_o2, red2, green2, yellow2, exp_y);
      end
    end
    flash_mode = 1'b0;
    tick();
    checks++;
    if ({state_o2, red2, phase_o2} !== {2'd0, 2'b11, 1'b0}) begin
      errors++;
      $display("FAIL flash_exit: got st=%0d r=%b ph=%0d, want st=0 r=11 ph=0", state_o2, red2, phase_o2);
    end
    tick();
    checks++;
    if ({state_o2, phase_o2, phase_start2, green2} !== {2'd1, 1'b1, 1'b1, 2'b10}) begin
      errors++;
      $display("FAIL flash_resume: got st=%0d ph=%0d ps=%b g=%b, want st=1 ph=1 ps=1 g=10",
               state_o2, phase_o2, phase_start2, green2);
    end
    $display("test_flash: done");
  endtask

  task automatic test_freeze();
    apply_reset();
    tick();
    repeat (8) tick();
    checks++;
    if ({state_o2, yellow2, red2} !== {2'd2, 2'b01, 2'b10}) begin
      errors++;
      $display("FAIL freeze_entry: got st=%0d y=%b r=%b, want st=2 y=01 r=10", state_o2, yellow2, red2);
    end
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({state_o2, yellow2, red2, green2} !== {2'd2, 2'b01, 2'b10, 2'b00}) begin
        errors++;
        $display("FAIL freeze_hold_%0d: got st=%0d y=%b r=%b g=%b, want st=2 y=01 r=10 g=00",
                 i, state_o2, yellow2, red2, green2);
      end
    end
    enable = 1'b1;
    tick();
    checks++;
    if (state_o2 !== 2'd2) begin
      errors++;
      $display("FAIL freeze_yellow_last: got st=%0d, want st=2", state_o2);
    end
    tick();
    checks++;
    if ({state_o2, red2} !== {2'd0, 2'b11}) begin
      errors++;
      $display("FAIL freeze_all_red: got st=%0d r=%b, want st=0 r=11", state_o2, red2);
    end
    tick();
    checks++;
    if ({state_o2, phase_o2} !== {2'd1, 1'b1}) begin
      errors++;
      $display("FAIL freeze_continue: got st=%0d ph=%0d, want st=1 ph=1", state_o2, phase_o2);
    end
    $display("test_freeze: done");
  endtask

  task automatic test_reset_mid_green();
    apply_reset();
    tick();
    repeat (11) tick();
    checks++;
    if ({state_o3, phase_o3} !== {2'd1, 2'd1}) begin
      errors++;
      $display("FAIL n3_phase1_green: got st=%0d ph=%0d, want st=1 ph=1", state_o3, phase_o3);
    end
    demand3 = 3'b100;
    tick();
    demand3 = '0;
    tick();
    reset = 1'b1;
    tick();
    checks++;
    if ({red3, yellow3, green3, state_o3, phase_o3, phase_start3} !== {3'b111, 3'b000, 3'b000, 2'd0, 2'd2, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid_green: got r=%b y=%b g=%b st=%0d ph=%0d ps=%b, want r=111 y=000 g=000 st=0 ph=2 ps=0",
               red3, yellow3, green3, state_o3, phase_o3, phase_start3);
    end
    reset = 1'b0;
    tick();
    checks++;
    if ({state_o3, phase_o3, phase_start3} !== {2'd1, 2'd0, 1'b1}) begin
      errors++;
      $display("FAIL reset_next_green: got st=%0d ph=%0d ps=%b, want st=1 ph=0 ps=1",
               state_o3, phase_o3, phase_start3);
    end
    $display("test_reset_mid_green: done");
  endtask

  initial begin
    test_reset();
    test_fixed_time();
    test_actuation();
    test_skip();
    test_flash();
    test_freeze();
    test_reset_mid_green();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/traffic_phase_ctrl.md
Name: traffic_phase_ctrl

Overview:
Parametrised multi-phase traffic intersection controller. It is the successor to the fixed three-state single-approach light. It sequences NUM_PHASES conflicting phases through GREEN -> YELLOW -> ALL_RED, and it adds the following:
- skipping of phases with no demand
- actuated green extension, capped at a maximum
- a flash override mode
- a freeze enable

It sits between the detector/pedestrian-button logic and the lamp drivers.

Parameters:
NUM_PHASES, 2, number of phases; legal range 2..8.
CNT_W, 8, timer width in bits.
GREEN_MIN, 8, minimum green length in cycles.
GREEN_MAX, 16, maximum green length in cycles; must be >= GREEN_MIN.
YELLOW_TIME, 2, yellow length in cycles.
ALL_RED_TIME, 1, all-red clearance length in cycles.
FLASH_HALF, 4, flash half-period in cycles.
(All durations: 1..2^CNT_W-1. PH_W = max(1, clog2(NUM_PHASES)) is a localparam.)

Ports:
clk  input  1  clock.
reset  input  1  reset; synchronous, active-high.
enable  input  1  when 0, the timer and state freeze.
flash_mode  input  1  flash override request.
demand  input  NUM_PHASES  per-phase vehicle/pedestrian request (level).
red  output  NUM_PHASES  per-phase red lamp.
yellow  output  NUM_PHASES  per-phase yellow lamp.
green  output  NUM_PHASES  per-phase green lamp.
phase_o  output  PH_W  current/last served phase index.
state_o  output  2  0=ALL_RED, 1=GREEN, 2=YELLOW, 3=FLASH.
phase_start  output  1  high only in the first cycle of each GREEN.

Behaviour:
- Reset (synchronous, active-high, takes effect on the clock edge, has priority over everything):
  - state=ALL_RED, counter=0, phase=NUM_PHASES-1, pending=0, blink=0.
  - Outputs: red=all 1, yellow=0, green=0, phase_o=NUM_PHASES-1, state_o=0, phase_start=0.
  - A reset issued mid-operation lands in the same state.
- Priority per edge: reset > flash_mode > enable=0 > normal sequencing.
- Timer: counter counts the cycles spent in the state, starting at 0. It clears on every state change.
- ALL_RED:
  - Lasts ALL_RED_TIME cycles.
  - On exit the phase becomes next_phase and the state becomes GREEN.
  - next_phase is the first i with pending[i]=1, searching (phase+1) mod N round-robin and ending at phase itself.
  - If no demand is pending anywhere, next_phase = (phase+1) mod N (fixed-time fallback).
- GREEN:
  - Let c be the counter value.
  - Exit to YELLOW when (c >= GREEN_MIN-1 and demand[phase]=0) or c = GREEN_MAX-1.
  - Green length is therefore GREEN_MIN..GREEN_MAX.
- YELLOW: lasts YELLOW_TIME cycles, then goes to ALL_RED.
- Pending latch:
  - pending[i] is set on any cycle with demand[i]=1, except while phase i is in GREEN (that demand counts as served).
  - pending[i] clears on the edge entering GREEN for phase i. Clear wins over a simultaneous set.
- FLASH:
  - flash_mode=1 enters FLASH on the next edge from any state, with counter=0 and blink=1.
  - While in FLASH, blink toggles each time the counter reaches FLASH_HALF-1; the counter wraps to 0 at that point.
  - Outputs in FLASH: red=0, green=0, yellow=all blink.
  - On flash_mode=0, FLASH goes to ALL_RED with counter 0. phase and pending are retained.
- enable=0 (and no flash): state, counter and pending hold; outputs are stable.
- Output decode (from registered state):
  - GREEN/YELLOW: only bit phase has green/yellow=1; every other phase has red=1.
  - ALL_RED: red=all 1.
  - phase_start = (state==GREEN && counter==0).
  - Exactly one lamp per phase is lit outside FLASH.
- Widths: counter is CNT_W bits and never exceeds its duration-1. The phase index wraps modulo NUM_PHASES; it must be correct for non-power-of-2 N.

Test Plan:
1. Fixed-time cycle (defaults, N=2, demand=0, enable=1): release reset -> ALL_RED 1 cycle, phase0 GREEN 8 cycles (phase_start in its first), YELLOW 2, ALL_RED 1, phase1 GREEN 8. Period is 22 cycles, and exactly one lamp per phase is lit every cycle.
2. Actuation: demand[0]=1 held -> phase0 green lasts 16 cycles (capped). Repeat with demand[0] dropped in green cycle 11 -> YELLOW on the next cycle (green length 11). demand[0]=0 throughout -> green length 8.
3. Skip (N=4): during phase0 green, pulse demand[2] for 1 cycle; no other demand -> after YELLOW/ALL_RED, phase_o=2 GREEN; phases 1 and 3 are skipped; pending[2]=0 afterwards.
4. Flash: assert flash_mode in green cycle 3 -> next cycle red=green=0 and yellow=all 1, toggling every 4 cycles. Deassert -> ALL_RED for 1 cycle, then the next phase per the round-robin rule.
5. Freeze: enable=0 for 5 cycles during YELLOW cycle 1 -> outputs unchanged; YELLOW lasts 7 cycles total; the sequence then continues normally.
6. Reset mid-green (N=3, phase1): reset=1 for 1 cycle -> next edge red=all 1, state_o=0, phase_o=2, pending=0. The next GREEN is phase0.
